// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus bundle: two requester push channels, the register file write port and decode read-address snoop.
// Modport master faces the requesters/decode; modport slave is taken by regfile_wb_arbiter.
interface regfile_wb_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          req0_valid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;
  logic          req1_ready;
  logic          RegWrite;
  logic [AW-1:0] WriteAddr;
  logic [DW-1:0] WriteData;
  logic [AW-1:0] ReadAddr1;
  logic [AW-1:0] ReadAddr2;
  logic          hazard1;
  logic          hazard2;

  modport master (
    output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data, ReadAddr1, ReadAddr2,
    input  req0_ready, req1_ready, RegWrite, WriteAddr, WriteData, hazard1, hazard2
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data, ReadAddr1, ReadAddr2,
    output req0_ready, req1_ready, RegWrite, WriteAddr, WriteData, hazard1, hazard2
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin merge of ALU (r0) and load (r1) writeback FIFOs onto the regfile write port; push->RegWrite 2 cycles.
// reqN_ready = !full from registered count only; hazards snoop all queued writes. Option: ZERO_REG_DROP_EN.
module regfile_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam int          PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [AW-1:0] addr_q [2][DEPTH];
  logic [AW-1:0] addr_d [2][DEPTH];
  logic [DW-1:0] data_q [2][DEPTH];
  logic [DW-1:0] data_d [2][DEPTH];
  logic [PW-1:0] rd_ptr_q [2];
  logic [PW-1:0] rd_ptr_d [2];
  logic [PW-1:0] wr_ptr_q [2];
  logic [PW-1:0] wr_ptr_d [2];
  logic [PW:0]   cnt_q [2];
  logic [PW:0]   cnt_d [2];
  logic          rr_q, rr_d;
  logic          reg_write_q, reg_write_d;
  logic [AW-1:0] write_addr_q, write_addr_d;
  logic [DW-1:0] write_data_q, write_data_d;

  logic          in_vld  [2];
  logic [AW-1:0] in_addr [2];
  logic [DW-1:0] in_data [2];
  logic          rdy [2];
  logic          nempty [2];
  logic          push [2];
  logic          pop [2];
  logic          haz1, haz2;

  always_comb begin
    in_vld[0]  = bus.req0_valid;
    in_addr[0] = bus.req0_addr;
    in_data[0] = bus.req0_data;
    in_vld[1]  = bus.req1_valid;
    in_addr[1] = bus.req1_addr;
    in_data[1] = bus.req1_data;
    for (int r = 0; r < 2; r++) begin
      rdy[r]    = (cnt_q[r] != FULL);
      nempty[r] = (cnt_q[r] != '0);
`ifdef ZERO_REG_DROP_EN
      // r0 writes are architecturally dead: accept the handshake, keep nothing
      push[r]   = in_vld[r] && rdy[r] && (in_addr[r] != '0);
`else
      push[r]   = in_vld[r] && rdy[r];
`endif
    end
    pop[0] = nempty[0] && (!nempty[1] || !rr_q);
    pop[1] = nempty[1] && (!nempty[0] ||  rr_q);
  end

  always_comb begin
    addr_d       = addr_q;
    data_d       = data_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    rr_d         = rr_q;
    reg_write_d  = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    for (int r = 0; r < 2; r++) begin
      if (push[r]) begin
        addr_d[r][wr_ptr_q[r]] = in_addr[r];
        data_d[r][wr_ptr_q[r]] = in_data[r];
        wr_ptr_d[r]            = wr_ptr_q[r] + 1'b1;
      end
      if (pop[r]) begin
        rd_ptr_d[r]  = rd_ptr_q[r] + 1'b1;
        reg_write_d  = 1'b1;
        write_addr_d = addr_q[r][rd_ptr_q[r]];
        write_data_d = data_q[r][rd_ptr_q[r]];
        rr_d         = (r == 0);
      end
      cnt_d[r] = cnt_q[r] + {{PW{1'b0}}, push[r]} - {{PW{1'b0}}, pop[r]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 2; r++) begin
        rd_ptr_q[r] <= '0;
        wr_ptr_q[r] <= '0;
        cnt_q[r]    <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          addr_q[r][i] <= '0;
          data_q[r][i] <= '0;
        end
      end
      rr_q         <= 1'b0;
      reg_write_q  <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
    end else begin
      addr_q       <= addr_d;
      data_q       <= data_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      rr_q         <= rr_d;
      reg_write_q  <= reg_write_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
    end
  end

  // An entry is live when its distance from the head is below the occupancy.
  always_comb begin
    logic [PW-1:0] off;
    haz1 = reg_write_q && (write_addr_q == bus.ReadAddr1);
    haz2 = reg_write_q && (write_addr_q == bus.ReadAddr2);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        off = PW'(i) - rd_ptr_q[r];
        if ({1'b0, off} < cnt_q[r]) begin
          if (addr_q[r][i] == bus.ReadAddr1) haz1 = 1'b1;
          if (addr_q[r][i] == bus.ReadAddr2) haz2 = 1'b1;
        end
      end
    end
`ifdef ZERO_REG_DROP_EN
    if (bus.ReadAddr1 == '0) haz1 = 1'b0;
    if (bus.ReadAddr2 == '0) haz2 = 1'b0;
`endif
  end

  assign bus.req0_ready = rdy[0];
  assign bus.req1_ready = rdy[1];
  assign bus.RegWrite   = reg_write_q;
  assign bus.WriteAddr  = write_addr_q;
  assign bus.WriteData  = write_data_q;
  assign bus.hazard1    = haz1;
  assign bus.hazard2    = haz2;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: inputs change and outputs are sampled on negedge, away from posedge.
module tb_regfile_wb_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  regfile_wb_arbiter_if #(.AW(AW), .DW(DW)) wb ();

  regfile_wb_arbiter #(.DEPTH(2), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (wb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    wb.req0_valid = 1'b0;
    wb.req1_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  int            i0, i1, nobs, stale;
  logic          v0, v1, r0, r1;
  logic [AW-1:0] obs_a [16];
  logic [DW-1:0] obs_d [16];

  initial begin
    wb.req0_valid = 1'b1;
    wb.req0_addr  = 5'd4;
    wb.req0_data  = 32'h1111_2222;
    wb.req1_valid = 1'b0;
    wb.req1_addr  = '0;
    wb.req1_data  = '0;
    wb.ReadAddr1  = 5'd4;
    wb.ReadAddr2  = 5'd0;

    // Reset state, with a valid request held that must be ignored
    repeat (2) @(negedge clk);
    chk("rst_regwrite", wb.RegWrite, 0);
    chk("rst_waddr", wb.WriteAddr, 0);
    chk("rst_wdata", wb.WriteData, 0);
    chk("rst_ready0", wb.req0_ready, 1);
    chk("rst_ready1", wb.req1_ready, 1);
    chk("rst_valid_ignored_hazard1", wb.hazard1, 0);
    idle_inputs();
    rst = 1'b1;

    // Single req0 write: accepted at edge 1, RegWrite after edge 2
    wb.req0_valid = 1'b1;
    wb.req0_addr  = 5'd5;
    wb.req0_data  = 32'hA5A5_0001;
    wb.ReadAddr1  = 5'd5;
    @(negedge clk);
    wb.req0_valid = 1'b0;
    chk("t1_e1_regwrite", wb.RegWrite, 0);
    chk("t1_e1_hazard1", wb.hazard1, 1);
    @(negedge clk);
    chk("t1_e2_regwrite", wb.RegWrite, 1);
    chk("t1_e2_waddr", wb.WriteAddr, 5);
    chk("t1_e2_wdata", wb.WriteData, 32'hA5A5_0001);
    chk("t1_e2_hazard1", wb.hazard1, 1);
    @(negedge clk);
    chk("t1_e3_regwrite", wb.RegWrite, 0);
    chk("t1_e3_waddr_hold", wb.WriteAddr, 5);
    chk("t1_e3_hazard1", wb.hazard1, 0);

    // Both requesters saturating: strict alternation starting with r0
    do_reset();
    i0 = 0; i1 = 0; nobs = 0;
    v0 = 1'b0; v1 = 1'b0; r0 = 1'b0; r1 = 1'b0;
    for (int c = 0; c < 80 && nobs < 16; c++) begin
      @(negedge clk);
      if (wb.RegWrite) begin
        obs_a[nobs] = wb.WriteAddr;
        obs_d[nobs] = wb.WriteData;
        nobs++;
      end
      if (v0 && r0) i0++;
      if (v1 && r1) i1++;
      v0 = (i0 < 8);
      v1 = (i1 < 8);
      wb.req0_valid = v0;
      wb.req0_addr  = AW'(1 + i0);
      wb.req0_data  = 32'h100 + DW'(i0);
      wb.req1_valid = v1;
      wb.req1_addr  = AW'(9 + i1);
      wb.req1_data  = 32'h200 + DW'(i1);
      r0 = wb.req0_ready;
      r1 = wb.req1_ready;
    end
    idle_inputs();
    chk("t2_write_count", nobs, 16);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("t2_addr_%0d", k), obs_a[k], (k % 2 == 0) ? 32'(1 + k / 2) : 32'(9 + k / 2));
      chk($sformatf("t2_data_%0d", k), obs_d[k], (k % 2 == 0) ? 32'h100 + 32'(k / 2) : 32'h200 + 32'(k / 2));
    end

    // FIFO1 fills behind a req0 grant; ready returns one cycle after its pop
    do_reset();
    wb.req0_valid = 1'b1; wb.req0_addr = 5'd20; wb.req0_data = 32'h20;
    wb.req1_valid = 1'b1; wb.req1_addr = 5'd21; wb.req1_data = 32'h21;
    @(negedge clk);
    chk("t3_e1_ready1", wb.req1_ready, 1);
    wb.req0_addr = 5'd23; wb.req0_data = 32'h23;
    wb.req1_addr = 5'd22; wb.req1_data = 32'h22;
    @(negedge clk);
    chk("t3_e2_ready1_full", wb.req1_ready, 0);
    chk("t3_e2_regwrite", wb.RegWrite, 1);
    chk("t3_e2_waddr_r0", wb.WriteAddr, 20);
    wb.req0_addr = 5'd25; wb.req0_data = 32'h25;
    wb.req1_addr = 5'd24; wb.req1_data = 32'h24;
    @(negedge clk);
    chk("t3_e3_ready1_back", wb.req1_ready, 1);
    chk("t3_e3_waddr_r1", wb.WriteAddr, 21);
    idle_inputs();
    repeat (6) @(negedge clk);

    // Hazard tracking for a single req1 write to r7
    do_reset();
    wb.ReadAddr1  = 5'd7;
    wb.ReadAddr2  = 5'd3;
    wb.req1_valid = 1'b1; wb.req1_addr = 5'd7; wb.req1_data = 32'h77;
    #1;
    chk("t4_incoming_not_checked", wb.hazard1, 0);
    @(negedge clk);
    wb.req1_valid = 1'b0;
    chk("t4_e1_hazard1", wb.hazard1, 1);
    chk("t4_e1_hazard2", wb.hazard2, 0);
    chk("t4_e1_regwrite", wb.RegWrite, 0);
    @(negedge clk);
    chk("t4_e2_regwrite", wb.RegWrite, 1);
    chk("t4_e2_waddr", wb.WriteAddr, 7);
    chk("t4_e2_hazard1", wb.hazard1, 1);
    chk("t4_e2_hazard2", wb.hazard2, 0);
    @(negedge clk);
    chk("t4_e3_hazard1", wb.hazard1, 0);
    chk("t4_e3_regwrite", wb.RegWrite, 0);

    // Asynchronous reset mid-cycle with writes queued and in flight
    do_reset();
    wb.req0_valid = 1'b1; wb.req0_addr = 5'd10; wb.req0_data = 32'h10;
    wb.req1_valid = 1'b1; wb.req1_addr = 5'd11; wb.req1_data = 32'h11;
    @(negedge clk);
    wb.req0_addr = 5'd12; wb.req0_data = 32'h12;
    wb.req1_addr = 5'd13; wb.req1_data = 32'h13;
    @(negedge clk);
    idle_inputs();
    wb.ReadAddr1 = 5'd12;
    wb.ReadAddr2 = 5'd13;
    #1;
    chk("t5_pre_hazard1", wb.hazard1, 1);
    chk("t5_pre_hazard2", wb.hazard2, 1);
    chk("t5_pre_regwrite", wb.RegWrite, 1);
    rst = 1'b0;
    #1;
    chk("t5_rst_regwrite", wb.RegWrite, 0);
    chk("t5_rst_waddr", wb.WriteAddr, 0);
    chk("t5_rst_wdata", wb.WriteData, 0);
    chk("t5_rst_hazard1", wb.hazard1, 0);
    chk("t5_rst_hazard2", wb.hazard2, 0);
    chk("t5_rst_ready1", wb.req1_ready, 1);
    #1;
    rst = 1'b1;
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (wb.RegWrite) stale++;
    end
    chk("t5_no_stale_write", stale, 0);
    chk("t5_post_hazard1", wb.hazard1, 0);

    // Address 0 handling
    do_reset();
    wb.ReadAddr1  = 5'd0;
    wb.ReadAddr2  = 5'd3;
    wb.req0_valid = 1'b1; wb.req0_addr = 5'd0; wb.req0_data = 32'hDEAD_0000;
    #1;
    chk("t6_ready0", wb.req0_ready, 1);
    @(negedge clk);
    idle_inputs();
`ifdef ZERO_REG_DROP_EN
    chk("t6_e1_hazard1", wb.hazard1, 0);
    @(negedge clk);
    chk("t6_e2_regwrite", wb.RegWrite, 0);
    chk("t6_e2_wdata", wb.WriteData, 0);
`else
    chk("t6_e1_hazard1", wb.hazard1, 1);
    @(negedge clk);
    chk("t6_e2_regwrite", wb.RegWrite, 1);
    chk("t6_e2_wdata", wb.WriteData, 32'hDEAD_0000);
`endif
    chk("t6_e2_waddr", wb.WriteAddr, 0);
    @(negedge clk);
    chk("t6_e3_regwrite", wb.RegWrite, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
